cmul_pipe: RTL and testbench
============================

# cmul_pipe

Pipelined, parametrised fixed-point complex multiplier with valid/ready flow control, selectable conjugate mode, rounding and saturation. It multiplies a data sample by a twiddle factor and returns a result scaled back to the data width. It replaces the single-cycle, fixed-16-bit twiddle multiplier in every radix-2 butterfly stage of the pipeline FFT. The same instance serves both forward FFT and IFFT through the conjugate control.

## Interface
Parameters:
- WIDTH, 16: bit width of each real/imag component of data, twiddle and result (two's complement).
- FRAC, WIDTH-1: fractional bits of the twiddle; the result is the full product shifted right by FRAC.
- ROUND, 1: 1 = round half up before the shift; 0 = truncate (floor).
- SAT, 1: 1 = saturate to the WIDTH range; 0 = wrap (keep the low WIDTH bits).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input this cycle.
- conj  in  1  sampled with the input; 1 = multiply by the conjugate of the twiddle.
- in_re, in_im  in  WIDTH  data sample, signed.
- wn_re, wn_im  in  WIDTH  twiddle, signed, Q(WIDTH-FRAC).FRAC.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_re, out_im  out  WIDTH  product, signed.
- out_ovf  out  1  saturation or wrap occurred on re or im for this result.

## Operation
- Transfer rule: a beat transfers when valid and ready are both high in the same cycle, on both sides.
- Conjugate: when conj = 1, wn_im is treated as its negation. The negation is applied in the arithmetic only, so −(−2^(WIDTH−1)) is exact.
- Arithmetic: pr = a·c − b·d and pi = a·d + b·c, where a/b are in_re/in_im and c/d are wn_re/wn_im (d negated if conj).
  - Products are 2·WIDTH bits; sums are 2·WIDTH+1 bits. No intermediate loss.
- Scaling:
  - If ROUND = 1, add 2^(FRAC−1) before the shift.
  - Arithmetic right shift by FRAC.
- Saturation:
  - If SAT = 1, clamp to [−2^(WIDTH−1), 2^(WIDTH−1)−1] and set out_ovf when clamped.
  - If SAT = 0, take the low WIDTH bits and set out_ovf when the value does not fit.
- Pipeline, 4 stages, each with its own valid bit:
  - S1: register the inputs and conj.
  - S2: four partial products.
  - S3: add/subtract.
  - S4: round, shift and saturate; drives the outputs.
- Stall: the pipeline advances only when !out_valid || out_ready. in_ready equals the same term.
  - When stalled, all stages hold and outputs stay stable.
  - Bubbles are not collapsed.
- Ordering: results leave strictly in input order. There is no loss and no duplication under any valid/ready pattern.

## Timing
- Latency: 4 cycles from the accepted input edge to out_valid, with no stall in between.
- Throughput: 1 result per cycle while out_ready stays high.
- in_ready is combinational from out_ready and out_valid only. It never depends on in_valid.
- Reset (asynchronous, on rst_n low):
  - All stage valids clear.
  - out_valid = 0, out_re = out_im = 0, out_ovf = 0, in_ready = 1.
- Reset mid-stream discards all in-flight samples. The first input after reset release appears after 4 cycles.
- Simultaneous events:
  - An accept and an emit in the same cycle are allowed; a full pipeline keeps streaming.
  - A stall with in_valid high does not capture the input.
- out_valid is registered.

## Structure
- Shared package fft_pkg holds:
  - The default data width (16).
  - The constant CMUL_LAT = 4, which downstream delay-line alignment uses.
  - A complex struct typedef for {re, im} at the default width.
- Sub-module cmul_rsat: combinational round/shift/saturate of one (2·WIDTH+1)-bit component. It has parameters WIDTH, FRAC, ROUND and SAT, outputs value plus ovf, and is instantiated twice in S4.

## Test plan
- Basic: in = (16384, 0), wn = (0, 32767), conj = 0 → out = (0, 16384), out_ovf = 0, out_valid exactly 4 cycles after the accept.
- Conjugate: same inputs with conj = 1 → out = (0, −16383).
- Saturation: in = (−32768, 0), wn = (−32768, 0), SAT = 1 → out_re = 32767, out_ovf = 1. With SAT = 0 → out_re = −32768, out_ovf = 1.
- Rounding: wn = (16384, 0).
  - in = (1, 0): ROUND = 1 → out_re = 1; ROUND = 0 → out_re = 0.
  - in = (−1, 0): ROUND = 1 → 0; ROUND = 0 → −1.
- Backpressure: stream 8 samples back to back and drop out_ready for 3 cycles mid-stream.
  - in_ready falls in the same cycles as out_ready.
  - All 8 results arrive in order with no duplicates.
  - Outputs are stable while stalled.
- Reset: assert rst_n low for 1 cycle with 3 samples in flight.
  - out_valid drops immediately and those samples never appear.
  - The next sample emerges after 4 cycles.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default sample width, complex sample
// type and the complex multiplier latency used for delay-line alignment.
package fft_pkg;

    localparam int DATA_W   = 16;
    localparam int CMUL_LAT = 4;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/cmul_rsat.sv
// Round / arithmetic-shift / saturate-or-wrap of one wide product component.
// Ports: x (2*WIDTH+1 signed) in; y (WIDTH signed) out; ovf out (value did not fit).
module cmul_rsat #(
    parameter int WIDTH = 16,
    parameter int FRAC  = WIDTH - 1,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic signed [2*WIDTH:0]  x,
    output logic signed [WIDTH-1:0]  y,
    output logic                     ovf
);

    // One extra headroom bit so the rounding constant never overflows.
    localparam int XW  = 2 * WIDTH + 2;
    localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic signed [XW-1:0] RND =
        (ROUND != 0 && FRAC > 0) ? (XW'(1) << RSH) : '0;
    localparam logic signed [XW-1:0] MAXV =
        {{(XW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [XW-1:0] MINV = ~MAXV;

    logic signed [XW-1:0] xr;
    logic signed [XW-1:0] sh;
    logic                 hi;
    logic                 lo;

    always_comb begin
        xr  = XW'(x) + RND;
        sh  = xr >>> FRAC;
        hi  = sh > MAXV;
        lo  = sh < MINV;
        ovf = hi | lo;
        y   = sh[WIDTH-1:0];
        if (SAT != 0) begin
            if (hi) begin
                y = MAXV[WIDTH-1:0];
            end else if (lo) begin
                y = MINV[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/cmul_pipe.sv
// 4-stage fixed-point complex multiplier (data x twiddle, optional conjugate)
// with valid/ready flow control, rounding and saturation.
// Ports: clk, rst_n; in_valid/in_ready, conj, in_re/in_im, wn_re/wn_im;
//        out_valid/out_ready, out_re/out_im, out_ovf.
module cmul_pipe
    import fft_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int FRAC  = WIDTH - 1,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    conj,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    input  logic signed [WIDTH-1:0] wn_re,
    input  logic signed [WIDTH-1:0] wn_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    out_ovf
);

    localparam int PW = 2 * WIDTH;
    localparam int SW = PW + 1;

    logic adv;

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, ov_q, ov_d;
    logic cj1_q, cj1_d, cj2_q, cj2_d;

    logic signed [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
    logic signed [WIDTH-1:0] c1_q, c1_d, d1_q, d1_d;

    logic signed [PW-1:0] ac_q, ac_d, bd_q, bd_d;
    logic signed [PW-1:0] ad_q, ad_d, bc_q, bc_d;

    logic signed [SW-1:0] pr_q, pr_d, pi_q, pi_d;

    logic signed [WIDTH-1:0] re_q, re_d, im_q, im_d;
    logic signed [WIDTH-1:0] rs_re, rs_im;
    logic                    ovf_q, ovf_d, ovf_re, ovf_im;

    // Whole pipeline moves as one; bubbles are carried, not collapsed.
    assign adv      = !ov_q || out_ready;
    assign in_ready = adv;

    cmul_rsat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ROUND (ROUND),
        .SAT   (SAT)
    ) u_rsat_re (
        .x   (pr_q),
        .y   (rs_re),
        .ovf (ovf_re)
    );

    cmul_rsat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ROUND (ROUND),
        .SAT   (SAT)
    ) u_rsat_im (
        .x   (pi_q),
        .y   (rs_im),
        .ovf (ovf_im)
    );

    always_comb begin
        v1_d  = v1_q;
        cj1_d = cj1_q;
        a1_d  = a1_q;
        b1_d  = b1_q;
        c1_d  = c1_q;
        d1_d  = d1_q;
        v2_d  = v2_q;
        cj2_d = cj2_q;
        ac_d  = ac_q;
        bd_d  = bd_q;
        ad_d  = ad_q;
        bc_d  = bc_q;
        v3_d  = v3_q;
        pr_d  = pr_q;
        pi_d  = pi_q;
        ov_d  = ov_q;
        re_d  = re_q;
        im_d  = im_q;
        ovf_d = ovf_q;
        if (adv) begin
            v1_d  = in_valid;
            cj1_d = conj;
            a1_d  = in_re;
            b1_d  = in_im;
            c1_d  = wn_re;
            d1_d  = wn_im;

            v2_d  = v1_q;
            cj2_d = cj1_q;
            ac_d  = PW'(a1_q) * PW'(c1_q);
            bd_d  = PW'(b1_q) * PW'(d1_q);
            ad_d  = PW'(a1_q) * PW'(d1_q);
            bc_d  = PW'(b1_q) * PW'(c1_q);

            // Conjugate flips the sign of every d term here, so the
            // most negative twiddle needs no representable negation.
            v3_d = v2_q;
            if (cj2_q) begin
                pr_d = SW'(ac_q) + SW'(bd_q);
                pi_d = SW'(bc_q) - SW'(ad_q);
            end else begin
                pr_d = SW'(ac_q) - SW'(bd_q);
                pi_d = SW'(ad_q) + SW'(bc_q);
            end

            ov_d  = v3_q;
            re_d  = rs_re;
            im_d  = rs_im;
            ovf_d = ovf_re | ovf_im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            cj1_q <= 1'b0;
            a1_q  <= '0;
            b1_q  <= '0;
            c1_q  <= '0;
            d1_q  <= '0;
            v2_q  <= 1'b0;
            cj2_q <= 1'b0;
            ac_q  <= '0;
            bd_q  <= '0;
            ad_q  <= '0;
            bc_q  <= '0;
            v3_q  <= 1'b0;
            pr_q  <= '0;
            pi_q  <= '0;
            ov_q  <= 1'b0;
            re_q  <= '0;
            im_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            v1_q  <= v1_d;
            cj1_q <= cj1_d;
            a1_q  <= a1_d;
            b1_q  <= b1_d;
            c1_q  <= c1_d;
            d1_q  <= d1_d;
            v2_q  <= v2_d;
            cj2_q <= cj2_d;
            ac_q  <= ac_d;
            bd_q  <= bd_d;
            ad_q  <= ad_d;
            bc_q  <= bc_d;
            v3_q  <= v3_d;
            pr_q  <= pr_d;
            pi_q  <= pi_d;
            ov_q  <= ov_d;
            re_q  <= re_d;
            im_q  <= im_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = ov_q;
    assign out_re    = re_q;
    assign out_im    = im_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cmul_pipe.sv
// Scoreboard bench for cmul_pipe: a default (round+saturate) instance and a
// truncate+wrap instance share all inputs; each has its own expected queue.
module tb_cmul_pipe;

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               ovf;
        bit                 lat;
        int                 acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, conj, out_ready;
    logic signed [15:0] in_re, in_im, wn_re, wn_im;

    logic               ir [2];
    logic               ov [2];
    logic signed [15:0] ore [2];
    logic signed [15:0] oim [2];
    logic               oovf [2];

    exp_t qa[$];
    exp_t qb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic               stl [2];
    logic               p_v [2];
    logic signed [15:0] p_re [2];
    logic signed [15:0] p_im [2];
    logic               p_ovf [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmul_pipe dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .conj(conj), .in_re(in_re), .in_im(in_im), .wn_re(wn_re),
        .wn_im(wn_im), .out_valid(ov[0]), .out_ready(out_ready),
        .out_re(ore[0]), .out_im(oim[0]), .out_ovf(oovf[0])
    );

    cmul_pipe #(.WIDTH(16), .FRAC(15), .ROUND(0), .SAT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .conj(conj), .in_re(in_re), .in_im(in_im), .wn_re(wn_re),
        .wn_im(wn_im), .out_valid(ov[1]), .out_ready(out_ready),
        .out_re(ore[1]), .out_im(oim[1]), .out_ovf(oovf[1])
    );

    task automatic chk(input bit ok, input string nm,
                       input int act, input int req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    task automatic send(input int re, input int im, input int wr,
                        input int wi, input bit cj,
                        input int e0r, input int e0i, input bit e0o,
                        input int e1r, input int e1i, input bit e1o,
                        input bit lat);
        exp_t e;
        int n;
        in_valid = 1'b1;
        conj  = cj;
        in_re = 16'(re);
        in_im = 16'(im);
        wn_re = 16'(wr);
        wn_im = 16'(wi);
        n = 0;
        forever begin
            @(negedge clk);
            if (ir[0]) break;
            n++;
            if (n > 50) break;
        end
        if (n > 50) begin
            chk(1'b0, "accept_timeout", n, 0);
        end else begin
            e.lat = lat;
            e.acc = cyc;
            e.re = 16'(e0r); e.im = 16'(e0i); e.ovf = e0o;
            qa.push_back(e);
            e.re = 16'(e1r); e.im = 16'(e1i); e.ovf = e1o;
            qb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk(qa.size() == 0 && qb.size() == 0, "drain",
            qa.size() + qb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stl[0] <= 1'b0;
            stl[1] <= 1'b0;
        end else begin
            chk(ir[0] == (!ov[0] || out_ready) && ir[1] == ir[0],
                "in_ready", int'(ir[0]), int'(!ov[0] || out_ready));
            for (int i = 0; i < 2; i++) begin
                if (stl[i]) begin
                    chk(ov[i] && ore[i] == p_re[i] && oim[i] == p_im[i] &&
                        oovf[i] == p_ovf[i], $sformatf("stall_hold%0d", i),
                        int'(ore[i]), int'(p_re[i]));
                end
                stl[i]   <= ov[i] && !out_ready;
                p_v[i]   <= ov[i];
                p_re[i]  <= ore[i];
                p_im[i]  <= oim[i];
                p_ovf[i] <= oovf[i];
                if (ov[i] && out_ready) begin
                    exp_t e;
                    if ((i == 0 ? qa.size() : qb.size()) == 0) begin
                        chk(1'b0, $sformatf("unexpected_out%0d", i),
                            int'(ore[i]), 0);
                    end else begin
                        e = (i == 0) ? qa.pop_front() : qb.pop_front();
                        chk(ore[i] == e.re, $sformatf("re%0d", i),
                            int'(ore[i]), int'(e.re));
                        chk(oim[i] == e.im, $sformatf("im%0d", i),
                            int'(oim[i]), int'(e.im));
                        chk(oovf[i] == e.ovf, $sformatf("ovf%0d", i),
                            int'(oovf[i]), int'(e.ovf));
                        if (e.lat) begin
                            chk(cyc - e.acc == 4, $sformatf("latency%0d", i),
                                cyc - e.acc, 4);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        conj = 1'b0;
        out_ready = 1'b1;
        in_re = '0; in_im = '0; wn_re = '0; wn_im = '0;
        stl[0] = 1'b0;
        stl[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk(!ov[i] && ore[i] == 0 && oim[i] == 0 && !oovf[i] && ir[i],
                $sformatf("reset_state%0d", i), int'(ov[i]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic, conjugate, saturation, rounding, -2^15 twiddle, imag overflow
        send(16384, 0, 0, 32767, 0,      0, 16384, 0,      0, 16383, 0, 1);
        send(16384, 0, 0, 32767, 1,      0, -16383, 0,     0, -16384, 0, 1);
        send(-32768, 0, -32768, 0, 0,    32767, 0, 1,      -32768, 0, 1, 1);
        send(1, 0, 16384, 0, 0,          1, 0, 0,          0, 0, 0, 1);
        send(-1, 0, 16384, 0, 0,         0, 0, 0,          -1, 0, 0, 1);
        send(16384, 0, 0, -32768, 1,     0, 16384, 0,      0, 16384, 0, 1);
        send(-32768, -32768, -32768, -32768, 0,
                                         0, 32767, 1,      0, 0, 1, 1);
        drain();

        // 8 back-to-back samples with a 3-cycle downstream stall
        fork
            begin
                for (int k = 1; k <= 8; k++) begin
                    send(k * 100, -k * 50, 16384, 0, 0,
                         k * 50, -k * 25, 0, k * 50, -k * 25, 0, 0);
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // reset with 3 samples in flight
        send(1000, 1000, 16384, 0, 0, 500, 500, 0, 500, 500, 0, 0);
        send(2000, 2000, 16384, 0, 0, 1000, 1000, 0, 1000, 1000, 0, 0);
        send(3000, 3000, 16384, 0, 0, 1500, 1500, 0, 1500, 1500, 0, 0);
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk(!ov[i] && ir[i] && ore[i] == 0 && !oovf[i],
                $sformatf("mid_reset%0d", i), int'(ov[i]), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(200, -400, 16384, 0, 0, 100, -200, 0, 100, -200, 0, 1);
        drain();
        repeat (6) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
